// File: rtl/register_file_mp.sv
// Multi-read-port integer register file with same-cycle write bypass and a
// per-register pending scoreboard used by decode for RAW hazard detection.
module register_file_mp #(
  parameter int unsigned  XLEN   = 32,
  parameter int unsigned  NREG   = 32,
  localparam int unsigned AW     = $clog2(NREG),
  parameter int unsigned  NRP    = 2,
  parameter int unsigned  SP_IDX = 2,
  parameter logic [31:0]  SP_RST = 32'h80000FFC,
  parameter bit           BYPASS = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                w_en,
  input  logic [AW-1:0]       rd,
  input  logic [XLEN-1:0]     write_data,
  input  logic                claim_en,
  input  logic [AW-1:0]       claim_idx,
  input  logic                r_en,
  input  logic [NRP*AW-1:0]   raddr,
  output logic [NRP*XLEN-1:0] rdata,
  output logic [NRP-1:0]      rbusy
);

  localparam logic [XLEN-1:0] SP_VAL   = XLEN'(SP_RST);
  localparam logic [AW-1:0]   IDX_ZERO = {AW{1'b0}};

  if ((NREG < 4) || ((NREG & (NREG - 1)) != 0)) begin : g_bad_nreg
    $error("register_file_mp: NREG must be a power of two and at least 4");
  end
  if ((NRP < 1) || (NRP > 4)) begin : g_bad_nrp
    $error("register_file_mp: NRP must be between 1 and 4");
  end
  if ((SP_IDX == 0) || (SP_IDX >= NREG)) begin : g_bad_sp
    $error("register_file_mp: SP_IDX must be nonzero and below NREG");
  end

  logic [XLEN-1:0]     regs_q [NREG];
  logic [XLEN-1:0]     regs_d [NREG];
  logic [NREG-1:0]     pending_q;
  logic [NREG-1:0]     pending_d;
  logic [NRP*XLEN-1:0] rdata_q;
  logic [NRP*XLEN-1:0] rdata_d;
  logic [NRP-1:0]      rbusy_q;
  logic [NRP-1:0]      rbusy_d;
  logic                wr_act_s;
  logic                claim_act_s;

  assign wr_act_s    = w_en && (rd != IDX_ZERO);
  assign claim_act_s = claim_en && (claim_idx != IDX_ZERO);

  // Next architectural state: the claim is applied after the write clear so a newer producer wins.
  always_comb begin
    regs_d    = regs_q;
    pending_d = pending_q;
    if (wr_act_s) begin
      regs_d[rd]    = write_data;
      pending_d[rd] = 1'b0;
    end else begin
      pending_d = pending_d;
    end
    if (claim_act_s) begin
      pending_d[claim_idx] = 1'b1;
    end else begin
      pending_d = pending_d;
    end
    regs_d[0]    = {XLEN{1'b0}};
    pending_d[0] = 1'b0;
  end

  for (genvar gi = 0; gi < NRP; gi++) begin : g_rport
    logic [AW-1:0]   ridx_s;
    logic            hit_s;
    logic [XLEN-1:0] data_d;
    logic            busy_d;

    assign ridx_s = raddr[gi*AW +: AW];
    assign hit_s  = (BYPASS != 1'b0) && w_en && (rd == ridx_s);

    // Per-port read select; a bypassed write also reports the register as no longer pending.
    always_comb begin
      data_d = rdata_q[gi*XLEN +: XLEN];
      busy_d = rbusy_q[gi];
      if (!r_en) begin
        data_d = rdata_q[gi*XLEN +: XLEN];
        busy_d = rbusy_q[gi];
      end else if (ridx_s == IDX_ZERO) begin
        data_d = {XLEN{1'b0}};
        busy_d = 1'b0;
      end else if (hit_s) begin
        data_d = write_data;
        busy_d = 1'b0;
      end else begin
        data_d = regs_q[ridx_s];
        busy_d = pending_q[ridx_s];
      end
    end

    assign rdata_d[gi*XLEN +: XLEN] = data_d;
    assign rbusy_d[gi]              = busy_d;
  end

  // State and read-output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned k = 0; k < NREG; k++) begin
        regs_q[k] <= (k == SP_IDX) ? SP_VAL : {XLEN{1'b0}};
      end
      pending_q <= {NREG{1'b0}};
      rdata_q   <= {(NRP*XLEN){1'b0}};
      rbusy_q   <= {NRP{1'b0}};
    end else begin
      regs_q    <= regs_d;
      pending_q <= pending_d;
      rdata_q   <= rdata_d;
      rbusy_q   <= rbusy_d;
    end
  end

  assign rdata = rdata_q;
  assign rbusy = rbusy_q;

endmodule
